// File: rtl/el2_lsu_error_pipe_if.sv
// LSU error pipe bus: D-stage address-check results in, registered R-stage
// error packet and first-error record handshake out.
interface el2_lsu_error_pipe_if #(
    parameter int CNT_W = 8
);
    logic             lsu_pkt_d_valid;
    logic             lsu_pkt_d_store;
    logic             lsu_pkt_d_dma;
    logic             lsu_pkt_d_fast_int;
    logic [31:0]      start_addr_d;
    logic             access_fault_d;
    logic             misaligned_fault_d;
    logic [3:0]       exc_mscause_d;
    logic             fir_dccm_access_error_d;
    logic             fir_nondccm_access_error_d;
    logic             flush_m;
    logic             flush_r;
    logic             lsu_error_pkt_r_valid;
    logic             lsu_error_pkt_r_store;
    logic             lsu_error_pkt_r_exc_type;
    logic [3:0]       lsu_error_pkt_r_mscause;
    logic [31:0]      lsu_error_pkt_r_addr;
    logic [1:0]       lsu_fir_error_r;
    logic             err_rec_valid;
    logic [31:0]      err_rec_addr;
    logic [3:0]       err_rec_mscause;
    logic             err_rec_exc_type;
    logic             err_rec_ack;
    logic             err_rec_ovf;
    logic [CNT_W-1:0] fault_cnt;
    logic             cnt_clr;

    modport master (
        output lsu_pkt_d_valid, lsu_pkt_d_store, lsu_pkt_d_dma,
        output lsu_pkt_d_fast_int, start_addr_d, access_fault_d,
        output misaligned_fault_d, exc_mscause_d,
        output fir_dccm_access_error_d, fir_nondccm_access_error_d,
        output flush_m, flush_r, err_rec_ack, cnt_clr,
        input  lsu_error_pkt_r_valid, lsu_error_pkt_r_store,
        input  lsu_error_pkt_r_exc_type, lsu_error_pkt_r_mscause,
        input  lsu_error_pkt_r_addr, lsu_fir_error_r,
        input  err_rec_valid, err_rec_addr, err_rec_mscause,
        input  err_rec_exc_type, err_rec_ovf, fault_cnt
    );

    modport slave (
        input  lsu_pkt_d_valid, lsu_pkt_d_store, lsu_pkt_d_dma,
        input  lsu_pkt_d_fast_int, start_addr_d, access_fault_d,
        input  misaligned_fault_d, exc_mscause_d,
        input  fir_dccm_access_error_d, fir_nondccm_access_error_d,
        input  flush_m, flush_r, err_rec_ack, cnt_clr,
        output lsu_error_pkt_r_valid, lsu_error_pkt_r_store,
        output lsu_error_pkt_r_exc_type, lsu_error_pkt_r_mscause,
        output lsu_error_pkt_r_addr, lsu_fir_error_r,
        output err_rec_valid, err_rec_addr, err_rec_mscause,
        output err_rec_exc_type, err_rec_ovf, fault_cnt
    );
endinterface

// File: rtl/el2_lsu_error_pipe.sv
// LSU error pipe: stages D-stage fault results through M and R, presents the
// R-stage error packet, holds a first-error record and a saturating count.
module el2_lsu_error_pipe #(
    parameter int CNT_W = 8
) (
    input logic                 clk,
    input logic                 rst_l,
    el2_lsu_error_pipe_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             w_exc_d;
    logic [1:0]       w_fir_d;
    logic             w_pkt_valid;
    logic             w_cap;
    logic             w_drop;

    logic             r_m_exc;
    logic             r_m_store;
    logic             r_m_type;
    logic [3:0]       r_m_mscause;
    logic [31:0]      r_m_addr;
    logic [1:0]       r_m_fir;

    logic             r_r_exc;
    logic             r_r_store;
    logic             r_r_type;
    logic [3:0]       r_r_mscause;
    logic [31:0]      r_r_addr;
    logic [1:0]       r_r_fir;

    logic             r_rec_valid;
    logic             r_rec_type;
    logic [3:0]       r_rec_mscause;
    logic [31:0]      r_rec_addr;
    logic             r_ovf;
    logic [CNT_W-1:0] r_cnt;

    // DMA never faults; DCCM error wins when both fast-int errors are set
    always_comb begin
        w_exc_d = bus.lsu_pkt_d_valid & ~bus.lsu_pkt_d_dma
                & (bus.access_fault_d | bus.misaligned_fault_d);
        w_fir_d = 2'b00;
        if (bus.lsu_pkt_d_valid & bus.lsu_pkt_d_fast_int) begin
            if (bus.fir_dccm_access_error_d) begin
                w_fir_d = 2'b01;
            end else if (bus.fir_nondccm_access_error_d) begin
                w_fir_d = 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_m_exc     <= 1'b0;
            r_m_store   <= 1'b0;
            r_m_type    <= 1'b0;
            r_m_mscause <= 4'h0;
            r_m_addr    <= 32'h0;
            r_m_fir     <= 2'b00;
            r_r_exc     <= 1'b0;
            r_r_store   <= 1'b0;
            r_r_type    <= 1'b0;
            r_r_mscause <= 4'h0;
            r_r_addr    <= 32'h0;
            r_r_fir     <= 2'b00;
        end else begin
            r_m_exc     <= w_exc_d & ~bus.flush_m;
            r_m_fir     <= w_fir_d & {2{~bus.flush_m}};
            r_m_store   <= bus.lsu_pkt_d_store;
            r_m_type    <= bus.misaligned_fault_d;
            r_m_mscause <= bus.exc_mscause_d;
            r_m_addr    <= bus.start_addr_d;
            r_r_exc     <= r_m_exc & ~bus.flush_m;
            r_r_fir     <= r_m_fir & {2{~bus.flush_m}};
            r_r_store   <= r_m_store;
            r_r_type    <= r_m_type;
            r_r_mscause <= r_m_mscause;
            r_r_addr    <= r_m_addr;
        end
    end

    assign w_pkt_valid = r_r_exc & ~bus.flush_r;
    assign w_cap       = w_pkt_valid & (~r_rec_valid | bus.err_rec_ack);
    assign w_drop      = w_pkt_valid & r_rec_valid & ~bus.err_rec_ack;

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_rec_valid   <= 1'b0;
            r_rec_type    <= 1'b0;
            r_rec_mscause <= 4'h0;
            r_rec_addr    <= 32'h0;
        end else if (w_cap) begin
            r_rec_valid   <= 1'b1;
            r_rec_type    <= r_r_type;
            r_rec_mscause <= r_r_mscause;
            r_rec_addr    <= r_r_addr;
        end else if (bus.err_rec_ack) begin
            r_rec_valid   <= 1'b0;
        end
    end

    // Clear wins over hold, but a same-cycle event is still accounted for
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_ovf <= 1'b0;
            r_cnt <= '0;
        end else begin
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (bus.cnt_clr) begin
                r_ovf <= 1'b0;
            end
            if (bus.cnt_clr) begin
                r_cnt <= {{(CNT_W-1){1'b0}}, w_pkt_valid};
            end else if (w_pkt_valid && r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.lsu_error_pkt_r_valid    = w_pkt_valid;
    assign bus.lsu_error_pkt_r_store    = r_r_store;
    assign bus.lsu_error_pkt_r_exc_type = r_r_type;
    assign bus.lsu_error_pkt_r_mscause  = r_r_mscause;
    assign bus.lsu_error_pkt_r_addr     = r_r_addr;
    assign bus.lsu_fir_error_r          = r_r_fir & {2{~bus.flush_r}};
    assign bus.err_rec_valid            = r_rec_valid;
    assign bus.err_rec_addr             = r_rec_addr;
    assign bus.err_rec_mscause          = r_rec_mscause;
    assign bus.err_rec_exc_type         = r_rec_type;
    assign bus.err_rec_ovf              = r_ovf;
    assign bus.fault_cnt                = r_cnt;
endmodule

// File: doc/el2_lsu_error_pipe.md
Name: el2_lsu_error_pipe

Overview:
- Downstream consumer of the LSU D-stage address-check results (access/misaligned faults, mscause, fast-interrupt errors).
- Stages those results through M and R in lockstep with the LSU pipe, applies flushes, and presents a registered error packet to the TLU at R.
- Holds a first-error record for the TLU with a valid/ack handshake and keeps a saturating delivered-error counter.

Parameters:
- CNT_W, 8, width of saturating delivered-error counter (legal 2..16).

Ports:
- clk  in  1  core clock
- rst_l  in  1  synchronous active-low reset
- lsu_pkt_d_valid  in  1  D-stage LSU packet valid
- lsu_pkt_d_store  in  1  packet is a store (else load)
- lsu_pkt_d_dma  in  1  DMA access; never raises errors
- lsu_pkt_d_fast_int  in  1  fast-interrupt vector fetch
- start_addr_d  in  32  D-stage start address
- access_fault_d  in  1  access fault from address check
- misaligned_fault_d  in  1  misaligned fault from address check
- exc_mscause_d  in  4  mscause for the fault
- fir_dccm_access_error_d  in  1  fast-int DCCM error
- fir_nondccm_access_error_d  in  1  fast-int non-DCCM error
- flush_m  in  1  kill D and M entries this cycle
- flush_r  in  1  kill R entry this cycle
- lsu_error_pkt_r_valid  out  1  exception delivered at R
- lsu_error_pkt_r_store  out  1  store=1 / load=0
- lsu_error_pkt_r_exc_type  out  1  0=access fault, 1=misaligned
- lsu_error_pkt_r_mscause  out  4  mscause
- lsu_error_pkt_r_addr  out  32  faulting address
- lsu_fir_error_r  out  2  01=DCCM, 10=non-DCCM, 00=none
- err_rec_valid  out  1  first-error record held
- err_rec_addr  out  32  record address
- err_rec_mscause  out  4  record mscause
- err_rec_exc_type  out  1  record type
- err_rec_ack  in  1  TLU consumes record
- err_rec_ovf  out  1  sticky: error dropped while record full
- fault_cnt  out  CNT_W  delivered-exception count
- cnt_clr  in  1  clear fault_cnt and err_rec_ovf

Behaviour:
- Reset (rst_l=0 at clk edge): all valids, record, ovf, fault_cnt, lsu_fir_error_r and all packet fields = 0.
- D qualify:
  - exc_d = valid & ~dma & (access_fault_d | misaligned_fault_d).
  - exc_type = misaligned_fault_d (misaligned wins when both set).
  - fir_d = valid & fast_int & (dccm ? 01 : nondccm ? 10 : 00).
  - Entry valid_d = exc_d | (fir_d != 0).
- Pipe: D->M->R registers advance every cycle, no stall. A D-cycle-n error appears at R outputs in cycle n+2.
- flush_m=1: the D entry is not captured into M and the M entry is not captured into R (both valids written 0).
- Output masking: lsu_error_pkt_r_valid = r_exc_q & ~flush_r; lsu_fir_error_r = r_fir_q masked by ~flush_r. Data fields remain registered and unmasked.
- Record (err_rec_*):
  - Capture occurs when lsu_error_pkt_r_valid is high and either err_rec_valid=0 or err_rec_ack=1 in the same cycle.
  - If err_rec_ack is high with no new error, the record clears next cycle.
  - If an error arrives while err_rec_valid=1 and ack=0, the error is dropped and err_rec_ovf sets.
  - ack while the record is empty is ignored.
- fault_cnt:
  - Increments by 1 per lsu_error_pkt_r_valid.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - cnt_clr has priority: next value is 1 if an increment occurs that same cycle, else 0.
  - err_rec_ovf clears on cnt_clr unless a drop occurs that same cycle.
- Fast-interrupt errors are not counted and not recorded.
- Reset asserted mid-pipe discards all in-flight entries; no output fires in the cycle after reset deasserts.

Test Plan:
- Load, access_fault=1, mscause=3, addr 0xF004_0000 at cycle 0 -> at cycle 2: valid=1, store=0, exc_type=0, mscause=3, addr=0xF004_0000; err_rec captured; fault_cnt=1.
- Store, access_fault=1 and misaligned=1, mscause=2 -> R shows exc_type=1, mscause=2; same packet with dma=1 -> nothing at R, fault_cnt unchanged.
- Error at cycle 0, flush_m at cycle 1 -> no R valid at cycle 2. Separately, flush_r at cycle 2 -> valid=0 that cycle; counter and record unchanged.
- Two errors (addr 0x100, then 0x200) with no ack -> record holds 0x100 and ovf=1. Ack in the same cycle as a third error (0x300) -> record becomes 0x300.
- CNT_W=2: five delivered errors -> fault_cnt saturates at 3. cnt_clr in the same cycle as an error -> fault_cnt=1.
- fast_int with fir_dccm=1 and fir_nondccm=1 -> lsu_fir_error_r=01 at cycle 2; lsu_error_pkt_r_valid=0; fault_cnt unchanged.
